// File: rtl/axil_slave_frontend_ldmx.sv
// axil_slave_frontend_ldmx: AXI4-Lite slave to strobe-style backend request bridge
// with independent read/write FSMs and a backend timeout that answers SLVERR.
module axil_slave_frontend_ldmx #(
    parameter int ADDR_LSB       = 2,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        axilClk,
    input  logic        axilRst,
    input  logic [31:0] s_araddr,
    input  logic        s_arvalid,
    output logic        s_arready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic        s_rvalid,
    input  logic        s_rready,
    input  logic [31:0] s_awaddr,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    input  logic        s_wvalid,
    output logic        s_wready,
    output logic [1:0]  s_bresp,
    output logic        s_bvalid,
    input  logic        s_bready,
    output logic [17:0] raddr,
    output logic        rstart,
    output logic        rready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic [17:0] waddr,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wstart,
    output logic        bready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic [15:0] rd_timeouts,
    output logic [15:0] wr_timeouts
);
    typedef enum logic [2:0] {R_IDLE, R_ISSUE, R_WAIT, R_RESP, R_RESP_TO, R_DRAIN} rstate_t;
    typedef enum logic [2:0] {W_IDLE, W_ISSUE, W_WAIT, W_RESP, W_RESP_TO, W_DRAIN} wstate_t;

    rstate_t     r_rstate, w_rnext;
    wstate_t     r_wstate, w_wnext;
    logic [15:0] r_rcnt, r_wcnt;
    logic        r_aw_got, r_w_got;
    logic        w_ar_hs, w_aw_hs, w_w_hs, w_aw_ok, w_w_ok, w_r_to, w_w_to;
    logic        w_unused;

    assign w_unused = ^{s_araddr, s_awaddr};
    assign w_ar_hs  = s_arready & s_arvalid;
    assign w_aw_hs  = s_awready & s_awvalid;
    assign w_w_hs   = s_wready & s_wvalid;
    assign w_aw_ok  = r_aw_got | w_aw_hs;
    assign w_w_ok   = r_w_got | w_w_hs;
    // a response arriving on the timeout cycle wins over the timeout
    assign w_r_to   = (r_rstate == R_WAIT) & ~rvalid & (r_rcnt == 16'(TIMEOUT_CYCLES));
    assign w_w_to   = (r_wstate == W_WAIT) & ~bvalid & (r_wcnt == 16'(TIMEOUT_CYCLES));

    always_comb begin
        w_rnext = r_rstate;
        rstart  = r_rstate == R_ISSUE;
        rready  = (r_rstate == R_WAIT) | (r_rstate == R_DRAIN);
        case (r_rstate)
            R_IDLE:    w_rnext = w_ar_hs ? R_ISSUE : R_IDLE;
            R_ISSUE:   w_rnext = R_WAIT;
            R_WAIT:    w_rnext = rvalid ? R_RESP : (w_r_to ? R_RESP_TO : R_WAIT);
            R_RESP:    w_rnext = s_rready ? R_IDLE : R_RESP;
            R_RESP_TO: w_rnext = s_rready ? R_DRAIN : R_RESP_TO;
            R_DRAIN:   w_rnext = rvalid ? R_IDLE : R_DRAIN;
            default:   w_rnext = R_IDLE;
        endcase
    end

    always_ff @(posedge axilClk) begin
        if (axilRst) begin
            r_rstate    <= R_IDLE;
            r_rcnt      <= '0;
            s_arready   <= 1'b0;
            s_rdata     <= '0;
            s_rresp     <= '0;
            s_rvalid    <= 1'b0;
            raddr       <= '0;
            rd_timeouts <= '0;
        end else begin
            r_rstate <= w_rnext;
            r_rcnt   <= (r_rstate == R_WAIT) ? r_rcnt + 16'd1 : 16'd0;
            case (r_rstate)
                R_IDLE: begin
                    s_arready <= ~w_ar_hs;
                    if (w_ar_hs) raddr <= s_araddr[ADDR_LSB+17:ADDR_LSB];
                end
                R_WAIT: begin
                    if (rvalid) begin
                        s_rdata  <= rdata;
                        s_rresp  <= rresp;
                        s_rvalid <= 1'b1;
                    end else if (w_r_to) begin
                        s_rdata     <= '0;
                        s_rresp     <= 2'b10;
                        s_rvalid    <= 1'b1;
                        rd_timeouts <= (rd_timeouts == 16'hFFFF) ? rd_timeouts : rd_timeouts + 16'd1;
                    end
                end
                R_RESP:    if (s_rready) begin s_rvalid <= 1'b0; s_arready <= 1'b1; end
                R_RESP_TO: if (s_rready) s_rvalid <= 1'b0;
                R_DRAIN:   if (rvalid) s_arready <= 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_wnext = r_wstate;
        wstart  = r_wstate == W_ISSUE;
        bready  = (r_wstate == W_WAIT) | (r_wstate == W_DRAIN);
        case (r_wstate)
            W_IDLE:    w_wnext = (w_aw_ok & w_w_ok) ? W_ISSUE : W_IDLE;
            W_ISSUE:   w_wnext = W_WAIT;
            W_WAIT:    w_wnext = bvalid ? W_RESP : (w_w_to ? W_RESP_TO : W_WAIT);
            W_RESP:    w_wnext = s_bready ? W_IDLE : W_RESP;
            W_RESP_TO: w_wnext = s_bready ? W_DRAIN : W_RESP_TO;
            W_DRAIN:   w_wnext = bvalid ? W_IDLE : W_DRAIN;
            default:   w_wnext = W_IDLE;
        endcase
    end

    always_ff @(posedge axilClk) begin
        if (axilRst) begin
            r_wstate    <= W_IDLE;
            r_wcnt      <= '0;
            r_aw_got    <= 1'b0;
            r_w_got     <= 1'b0;
            s_awready   <= 1'b0;
            s_wready    <= 1'b0;
            s_bresp     <= '0;
            s_bvalid    <= 1'b0;
            waddr       <= '0;
            wdata       <= '0;
            wstrb       <= '0;
            wr_timeouts <= '0;
        end else begin
            r_wstate <= w_wnext;
            r_wcnt   <= (r_wstate == W_WAIT) ? r_wcnt + 16'd1 : 16'd0;
            case (r_wstate)
                W_IDLE: begin
                    s_awready <= ~w_aw_ok;
                    s_wready  <= ~w_w_ok;
                    if (w_aw_hs) begin waddr <= s_awaddr[ADDR_LSB+17:ADDR_LSB]; r_aw_got <= 1'b1; end
                    if (w_w_hs) begin wdata <= s_wdata; wstrb <= s_wstrb; r_w_got <= 1'b1; end
                    if (w_aw_ok & w_w_ok) begin r_aw_got <= 1'b0; r_w_got <= 1'b0; end
                end
                W_WAIT: begin
                    if (bvalid) begin
                        s_bresp  <= bresp;
                        s_bvalid <= 1'b1;
                    end else if (w_w_to) begin
                        s_bresp     <= 2'b10;
                        s_bvalid    <= 1'b1;
                        wr_timeouts <= (wr_timeouts == 16'hFFFF) ? wr_timeouts : wr_timeouts + 16'd1;
                    end
                end
                W_RESP: if (s_bready) begin
                    s_bvalid  <= 1'b0;
                    s_awready <= 1'b1;
                    s_wready  <= 1'b1;
                end
                W_RESP_TO: if (s_bready) s_bvalid <= 1'b0;
                W_DRAIN: if (bvalid) begin s_awready <= 1'b1; s_wready <= 1'b1; end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_axil_slave_frontend_ldmx.sv
// tb_axil_slave_frontend_ldmx: directed self-checking bench for the AXI-Lite
// front-end, built with a 16-cycle backend timeout.
module tb_axil_slave_frontend_ldmx;
    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] s_araddr = '0, s_awaddr = '0, s_wdata = '0, rdata = '0;
    logic        s_arvalid = 1'b0, s_rready = 1'b0, s_awvalid = 1'b0, s_wvalid = 1'b0, s_bready = 1'b0;
    logic [3:0]  s_wstrb = '0;
    logic [1:0]  rresp = '0, bresp = '0;
    logic        rvalid = 1'b0, bvalid = 1'b0;
    logic        s_arready, s_rvalid, s_awready, s_wready, s_bvalid;
    logic [31:0] s_rdata, wdata;
    logic [1:0]  s_rresp, s_bresp;
    logic [17:0] raddr, waddr;
    logic        rstart, rready, wstart, bready;
    logic [3:0]  wstrb;
    logic [15:0] rd_timeouts, wr_timeouts;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    axil_slave_frontend_ldmx #(.ADDR_LSB(2), .TIMEOUT_CYCLES(16)) dut (
        .axilClk(clk), .axilRst(rst),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .raddr(raddr), .rstart(rstart), .rready(rready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid),
        .waddr(waddr), .wdata(wdata), .wstrb(wstrb), .wstart(wstart), .bready(bready),
        .bresp(bresp), .bvalid(bvalid),
        .rd_timeouts(rd_timeouts), .wr_timeouts(wr_timeouts)
    );

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        tick(2);
        chk("rst_arready", {31'd0, s_arready}, 0);
        chk("rst_awready", {31'd0, s_awready}, 0);
        chk("rst_wready", {31'd0, s_wready}, 0);
        chk("rst_outs", {25'd0, rstart, rready, wstart, bready, s_rvalid, s_bvalid, |raddr}, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_readys", {29'd0, s_arready, s_awready, s_wready}, 32'h7);

        // basic read with backend answering two cycles after rstart
        s_araddr = 32'h400; s_arvalid = 1'b1;
        tick();
        s_arvalid = 1'b0;
        chk("rd_issue", {31'd0, rstart}, 1);
        chk("rd_raddr", {14'd0, raddr}, 32'h100);
        chk("rd_arready_low", {31'd0, s_arready}, 0);
        tick();
        chk("rd_single_rstart", {30'd0, rstart, rready}, 32'h1);
        tick();
        rvalid = 1'b1; rdata = 32'h12345678; rresp = 2'b00;
        tick();
        rvalid = 1'b0;
        chk("rd_svalid", {31'd0, s_rvalid}, 1);
        chk("rd_sdata", s_rdata, 32'h12345678);
        chk("rd_sresp", {30'd0, s_rresp}, 0);
        chk("rd_rready_off", {31'd0, rready}, 0);
        s_rready = 1'b1;
        tick();
        s_rready = 1'b0;
        chk("rd_done", {30'd0, s_rvalid, s_arready}, 32'h1);

        // W three cycles ahead of AW
        s_wdata = 32'hCAFEF00D; s_wstrb = 4'hF; s_wvalid = 1'b1;
        tick();
        s_wvalid = 1'b0;
        chk("wr_w_first", {30'd0, s_awready, s_wready}, 32'h2);
        tick(2);
        chk("wr_no_early_start", {31'd0, wstart}, 0);
        s_awaddr = 32'h00044000; s_awvalid = 1'b1;
        tick();
        s_awvalid = 1'b0;
        chk("wr_wstart", {31'd0, wstart}, 1);
        chk("wr_waddr", {14'd0, waddr}, 32'h11000);
        chk("wr_wdata", wdata, 32'hCAFEF00D);
        chk("wr_wstrb", {28'd0, wstrb}, 32'hF);
        tick();
        chk("wr_single_wstart", {30'd0, wstart, bready}, 32'h1);
        bvalid = 1'b1; bresp = 2'b00;
        tick();
        bvalid = 1'b0;
        chk("wr_bvalid", {29'd0, s_bvalid, s_bresp}, 32'h4);
        tick();
        chk("wr_bvalid_hold", {29'd0, s_bvalid, s_awready, s_wready}, 32'h4);
        s_bready = 1'b1;
        tick();
        s_bready = 1'b0;
        chk("wr_done", {29'd0, s_bvalid, s_awready, s_wready}, 32'h3);

        // backend decode error passes through
        s_araddr = 32'h8; s_arvalid = 1'b1;
        tick();
        s_arvalid = 1'b0;
        chk("dec_raddr", {14'd0, raddr}, 32'h2);
        tick();
        rvalid = 1'b1; rdata = 32'hDEADBEEF; rresp = 2'b11;
        tick();
        rvalid = 1'b0;
        chk("dec_resp", {29'd0, s_rvalid, s_rresp}, 32'h7);
        chk("dec_data", s_rdata, 32'hDEADBEEF);
        s_rready = 1'b1;
        tick();
        s_rready = 1'b0;

        // read timeout, then a late rvalid drains while a new AR waits
        s_araddr = 32'h10; s_arvalid = 1'b1;
        tick();
        s_arvalid = 1'b0;
        tick(17);
        chk("to_not_yet", {30'd0, s_rvalid, rready}, 32'h1);
        tick();
        chk("to_svalid", {30'd0, s_rvalid, rready}, 32'h2);
        chk("to_resp", {30'd0, s_rresp}, 32'h2);
        chk("to_data", s_rdata, 0);
        chk("to_count", {16'd0, rd_timeouts}, 1);
        s_rready = 1'b1;
        tick();
        s_rready = 1'b0;
        chk("to_drain", {29'd0, s_rvalid, s_arready, rready}, 32'h1);
        s_araddr = 32'h20; s_arvalid = 1'b1;
        tick(2);
        chk("to_ar_blocked", {30'd0, s_arready, rstart}, 0);
        rvalid = 1'b1; rdata = 32'h55;
        tick();
        rvalid = 1'b0;
        chk("to_drained", {30'd0, s_arready, s_rvalid}, 32'h2);
        tick();
        s_arvalid = 1'b0;
        chk("to_next_issue", {13'd0, rstart, raddr}, 32'h40008);
        tick();
        rvalid = 1'b1; rdata = 32'h77; rresp = 2'b00;
        tick();
        rvalid = 1'b0;
        chk("to_next_data", s_rdata, 32'h77);
        s_rready = 1'b1;
        tick();
        s_rready = 1'b0;

        // concurrent read and write with stalled masters
        s_araddr = 32'h40; s_arvalid = 1'b1;
        s_awaddr = 32'h80; s_awvalid = 1'b1;
        s_wdata = 32'h11223344; s_wstrb = 4'h3; s_wvalid = 1'b1;
        tick();
        s_arvalid = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0;
        chk("cc_starts", {30'd0, rstart, wstart}, 32'h3);
        chk("cc_waddr", {14'd0, waddr}, 32'h20);
        tick();
        rvalid = 1'b1; rdata = 32'hA5A5A5A5; rresp = 2'b00;
        bvalid = 1'b1; bresp = 2'b01;
        tick();
        rvalid = 1'b0; bvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("cc_hold_valids", {28'd0, s_rvalid, s_bvalid, rstart, wstart}, 32'hC);
            chk("cc_hold_data", s_rdata, 32'hA5A5A5A5);
            chk("cc_hold_bresp", {30'd0, s_bresp}, 32'h1);
            tick();
        end
        s_rready = 1'b1; s_bready = 1'b1;
        tick();
        s_rready = 1'b0; s_bready = 1'b0;
        chk("cc_done", {27'd0, s_rvalid, s_bvalid, s_arready, s_awready, s_wready}, 32'h7);

        // write timeout and drain
        s_awaddr = 32'h4; s_awvalid = 1'b1; s_wvalid = 1'b1;
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        tick(18);
        chk("wto_resp", {29'd0, s_bvalid, s_bresp}, 32'h6);
        chk("wto_count", {16'd0, wr_timeouts}, 1);
        s_bready = 1'b1;
        tick();
        s_bready = 1'b0;
        chk("wto_drain", {28'd0, s_bvalid, s_awready, s_wready, bready}, 32'h1);
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        chk("wto_drained", {29'd0, s_awready, s_wready, bready}, 32'h6);

        // reset in the middle of a read
        s_araddr = 32'h4; s_arvalid = 1'b1;
        tick();
        s_arvalid = 1'b0;
        tick();
        chk("mr_wait", {31'd0, rready}, 1);
        rst = 1'b1;
        tick();
        chk("mr_outs", {26'd0, rready, rstart, s_arready, s_awready, s_wready, s_rvalid}, 0);
        chk("mr_counts", {rd_timeouts, wr_timeouts}, 0);
        chk("mr_addrs", {14'd0, raddr}, 0);
        rst = 1'b0;
        tick();
        chk("mr_arready", {30'd0, s_arready, s_rvalid}, 32'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
